imem_fetch: RTL
===============

// Module: imem_fetch
// PURPOSE
//  Instruction fetch stage between the PC/branch logic and the 2048x32 BSRAM
//  instruction memory (synchronous read, 1-cycle latency, bypass mode).
//  Drives the memory address and chip enable, tracks the one in-flight read,
//  and buffers returned words in a 2-entry FIFO. Delivers {pc, instr} to decode
//  over a valid/ready handshake at 1 instr/cycle, and flushes on redirect.
// PARAMETERS
//  ADDR_W    11            word-address width of instruction memory (2^ADDR_W words)
//  RESET_PC  32'h0000_0000 first PC fetched after reset
// PORTS
//  clk             in   1       clock
//  reset_n         in   1       asynchronous active-low reset
//  imem_ad         out  ADDR_W  memory word address = pc[ADDR_W+1:2]
//  imem_ce         out  1       memory read enable; high = issue read this cycle
//  imem_oce        out  1       output-register enable; tied 1
//  imem_dout       in   32      read data, valid the cycle after a ce=1 cycle
//  redirect_valid  in   1       branch/jump/trap redirect request
//  redirect_pc     in   32      redirect target; bits [1:0] ignored
//  if_valid        out  1       fetched instruction available
//  if_ready        in   1       decode accepts instruction
//  if_pc           out  32      PC of presented instruction
//  if_instr        out  32      presented instruction word
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low.
//  Reset (async): pc=RESET_PC, fifo empty (count=0), inflight=0, kill=0.
//   Outputs during reset: if_valid=0, if_pc=0, if_instr=0, imem_ce=0, imem_ad=0.
//  State: pc reg, inflight flag + inflight_pc, 2-entry FIFO {pc,instr}.
//  pop  = if_valid & if_ready.
//  issue = ~redirect_valid & (count + inflight - pop < 2); imem_ce = issue.
//   issue and imem_ad are combinational from registered state.
//  On issue: inflight<=1, inflight_pc<=pc, pc<=pc+4.
//   pc wraps modulo 2^32; imem_ad wraps modulo 2^ADDR_W.
//  If no issue and no redirect: inflight<=0 at the edge.
//  Response: a cycle with inflight=1 and kill=0 pushes {inflight_pc, imem_dout}.
//   With kill=1 the data is discarded and kill<=0.
//   imem_dout is sampled only in that cycle; while ce=0 it is not read.
//  Latency: ce=1 in cycle N -> FIFO write at end of N+1 -> if_valid in N+2.
//  Throughput: steady state count=1 and inflight=1 sustain 1 pop/cycle.
//   count never exceeds 2; push to a full FIFO is impossible by construction.
//  if_valid = (count!=0); if_pc/if_instr = head entry, held stable while
//   if_valid & ~if_ready.
//  Redirect (redirect_valid=1):
//   - A pop in the same cycle completes first (decode consumed the old head).
//   - Then the FIFO is flushed to count=0.
//   - An inflight read issued in the previous cycle is killed: kill<=inflight,
//     inflight<=0.
//   - pc<={redirect_pc[31:2],2'b00}; no issue this cycle.
//   - Next cycle issues the target; its if_valid appears 2 cycles later.
//   - Back-to-back redirects: the last one wins; each suppresses issue.
//   - Redirect with an empty pipeline behaves the same (kill stays 0).
//  Stall: if_ready=0 with count=2 -> imem_ce=0, pc holds, nothing lost.
//  Reset asserted mid-operation: immediate clear; the in-flight word is dropped.
//  Fetch restarts from RESET_PC on the first cycle after reset release.
// TESTING
//  1. Reset release, if_ready=1, mem[i]=i:
//     ce=1 every cycle from cycle 0; if_valid from cycle 2;
//     (if_pc,if_instr)=(0,0),(4,1),(8,2)... one per cycle.
//  2. if_ready=0 for 5 cycles after the first valid:
//     count saturates at 2, ce=0, if_pc=0 held;
//     on release, pcs 0,4,8 delivered in order with no gap or duplicate.
//  3. redirect_pc=0x41 while count=2 and inflight=1:
//     all discarded; next delivered if_pc=0x40 with instr=mem[16] exactly
//     3 cycles after the redirect cycle.
//  4. Redirect in the same cycle as a pop of pc=0x8:
//     pc 0x8 counted consumed once; no stale 0xC appears; next pc=target.
//  5. pc=0x1FFC with ADDR_W=11:
//     imem_ad=0x7FF, then 0x000 for pc=0x2000; if_pc=0x2000 unchanged upper bits.
//  6. Random if_ready/redirect for 10k cycles vs reference model:
//     in-order, no loss or duplication; count<=2; if_pc word-aligned.

Source files
------------

// File: rtl/imem_fetch_if.sv
// ---------------------------------------------------------------------------
// imem_fetch_if
//   Bundle of every bus/handshake signal around the instruction fetch stage.
//   master : the fetch stage (drives memory address/enables and the decode
//            side valid/pc/instr).
//   slave  : the environment (BSRAM read data, redirect source, decode ready).
//   Signals:
//     imem_ad/imem_ce/imem_oce  fetch -> BSRAM  word address, read enable,
//                                               output-register enable
//     imem_dout                 BSRAM -> fetch  read data (1-cycle latency)
//     redirect_valid/_pc        PC logic -> fetch  branch/jump/trap target
//     if_valid/if_pc/if_instr   fetch -> decode
//     if_ready                  decode -> fetch
// ---------------------------------------------------------------------------
interface imem_fetch_if #(
  parameter int ADDR_W = 11
) ();
  logic [ADDR_W-1:0] imem_ad;
  logic              imem_ce;
  logic              imem_oce;
  logic [31:0]       imem_dout;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_pc;
  logic [31:0]       if_instr;

  modport master (
    output imem_ad, imem_ce, imem_oce,
    input  imem_dout,
    input  redirect_valid, redirect_pc,
    output if_valid, if_pc, if_instr,
    input  if_ready
  );

  modport slave (
    input  imem_ad, imem_ce, imem_oce,
    output imem_dout,
    output redirect_valid, redirect_pc,
    input  if_valid, if_pc, if_instr,
    output if_ready
  );
endinterface

// File: rtl/imem_fetch.sv
// ---------------------------------------------------------------------------
// imem_fetch
//   Instruction fetch stage in front of a synchronous-read instruction BSRAM
//   (1-cycle read latency). Issues one read per cycle while there is room,
//   tracks the single read in flight, buffers returned words in a 2-entry
//   FIFO of {pc, instr} and hands them to decode over valid/ready.
//   A redirect flushes everything fetched so far and restarts at the target.
//
//   Ports:
//     clk      clock
//     reset_n  asynchronous active-low reset
//     bus      imem_fetch_if.master (memory side + redirect + decode side)
//
//   Parameters:
//     ADDR_W    word-address width of the instruction memory
//     RESET_PC  first PC fetched after reset
// ---------------------------------------------------------------------------
module imem_fetch #(
  parameter int          ADDR_W   = 11,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset_n,
  imem_fetch_if.master bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [31:0] pc_q,      pc_d;
  logic        infl_q,    infl_d;     // read issued last cycle, data on imem_dout now
  logic [31:0] infl_pc_q, infl_pc_d;
  logic        kill_q,    kill_d;     // discard the response seen this cycle
  fetch_ent_t  fifo_q [2];
  logic        rd_ptr_q,  rd_ptr_d;
  logic        wr_ptr_q,  wr_ptr_d;
  logic [1:0]  cnt_q,     cnt_d;

  // ------------------------------------------------------------------------
  // Handshake / control
  // ------------------------------------------------------------------------
  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ_after_pop;

  assign pop = (cnt_q != 2'd0) & bus.if_ready;

  // Slots already committed (buffered + in flight) once this cycle's pop is
  // taken out. pop implies cnt_q>=1, so the subtraction never underflows.
  // Issuing only while this is below 2 keeps cnt+inflight<=2, which is what
  // guarantees a returning word always has a free FIFO slot.
  assign occ_after_pop = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign issue         = ~bus.redirect_valid & (occ_after_pop < 3'd2);

  // A response is captured only in the cycle after its read was issued.
  // A redirect in that same cycle flushes the FIFO, so the word is dropped too.
  assign push = infl_q & ~kill_q & ~bus.redirect_valid;

  // ------------------------------------------------------------------------
  // Next state
  // ------------------------------------------------------------------------
  always_comb begin
    pc_d      = pc_q;
    infl_d    = issue;
    infl_pc_d = infl_pc_q;
    kill_d    = 1'b0;
    if (bus.redirect_valid) begin
      pc_d   = bus.redirect_pc & ~32'h3;
      kill_d = infl_q;
    end else if (issue) begin
      infl_pc_d = pc_q;
      pc_d      = pc_q + 32'd4;   // wraps modulo 2^32
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    if (bus.redirect_valid) begin
      // Flush: the pop (if any) is already accounted for by decode; just
      // collapse the FIFO to empty at the current write position.
      cnt_d    = 2'd0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
      rd_ptr_d = rd_ptr_q ^ pop;
    end
  end

  // ------------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= 32'h0;
      kill_q    <= 1'b0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      kill_q    <= kill_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // FIFO storage is reset so the head reads as zero while in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= '{pc: infl_pc_q, instr: bus.imem_dout};
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  fetch_ent_t head;
  assign head = fifo_q[rd_ptr_q];

  assign bus.if_valid = (cnt_q != 2'd0);
  assign bus.if_pc    = head.pc;
  assign bus.if_instr = head.instr;

  // Memory side is forced quiet while reset is held, independent of the
  // value RESET_PC would otherwise put on the address.
  assign bus.imem_ce  = issue & reset_n;
  assign bus.imem_ad  = reset_n ? pc_q[ADDR_W+1:2] : '0;
  assign bus.imem_oce = 1'b1;

endmodule
